set_lookup_ctrl: RTL and testbench
==================================

SET_LOOKUP_CTRL -- requirements
Module: set_lookup_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: request and memory address width.
REQ-002 Parameter TAG_W, default 24: tag field, addr[31:8].
REQ-003 Parameter INDEX_W, default 2: set index, addr[7:6], giving 4 sets.
REQ-004 Parameter OFFSET_W, default 6: block offset, addr[5:0]; ignored for lookup.
REQ-005 Parameter WAYS, default 4: ways per set; way index is 2 bits.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  controller accepts a request.
REQ-010 req_addr  in  ADDR_W  request byte address.
REQ-011 req_write  in  1  1 = store, 0 = load.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_hit  out  1  1 = request hit, 0 = serviced by a fill.
REQ-014 block_num  out  4  {set,way} of the touched block; drives the downstream data set.
REQ-015 set_enable  out  1  one-cycle strobe to the downstream data set; coincident with resp_valid.
REQ-016 mem_req_valid  out  1  memory request (writeback or fill) pending.
REQ-017 mem_req_write  out  1  1 = writeback of victim, 0 = fill.
REQ-018 mem_req_addr  out  ADDR_W  block-aligned address, with offset bits 0.
REQ-019 mem_ack  in  1  memory completes the pending request.

Function
REQ-020 Tag store: per set, per way: valid bit, dirty bit, TAG_W tag, 2-bit LRU age.
REQ-021 FSM states: IDLE, LOOKUP, WB, FILL, RESP.
REQ-022 req_ready is 1 only in IDLE; handshake occurs when req_valid & req_ready; addr/write captured that edge; state goes to LOOKUP.
REQ-023 LOOKUP, hit (valid & tag match in captured set): goes to RESP; load hits complete 2 cycles after acceptance.
REQ-024 LOOKUP, miss: select victim: lowest-index invalid way, else the way with age 3.
REQ-025 Miss with a valid and dirty victim: goes to WB with mem_req_write=1 and mem_req_addr={victim tag,index,6'b0}; otherwise goes to FILL.
REQ-026 WB: hold mem_req_* stable until mem_ack=1; on ack goes to FILL.
REQ-027 FILL: mem_req_valid=1, mem_req_write=0, mem_req_addr={req tag,index,6'b0}, held until mem_ack; on ack write tag, valid=1, dirty=req_write; then goes to RESP.
REQ-028 RESP: resp_valid=1, set_enable=1 and block_num={index,way} for exactly one cycle; then goes to IDLE.
REQ-029 A store hit sets the dirty bit of that way in LOOKUP.
REQ-030 LRU update on RESP: touched way age=0; same-set ways whose age was below the old age increment; other ways unchanged; ages in each set remain a permutation of 0..3.
REQ-031 mem_ack outside WB/FILL is ignored; an ack in the first cycle of WB/FILL is accepted.
REQ-032 req_valid while req_ready=0 has no effect; no request queueing.
REQ-033 Only one memory request at a time; mem_req_valid deasserts the cycle after an accepted ack unless WB is followed directly by FILL.

Reset
REQ-034 rst asserted: state=IDLE; all valid and dirty bits = 0; ages per set = way index (0,1,2,3).
REQ-035 rst asserted: resp_valid, resp_hit, set_enable, mem_req_valid and mem_req_write = 0; block_num and mem_req_addr = 0; req_ready = 0 while rst is high.
REQ-036 Reset mid-operation aborts the transaction with no response; mem_req_valid drops asynchronously.

Verification
REQ-037 After reset, load 0x0000_1240 -> FILL with mem_req_addr=0x0000_1240; ack -> resp_hit=0, block_num=4'b0100 (set 1, way 0).
REQ-038 Repeat the same load -> resp_valid 2 cycles after acceptance, resp_hit=1, block_num=4'b0100, no mem_req_valid.
REQ-039 Fill set 0 with 4 loads (tags 1..4), then store tag 1, then load tag 5 -> victim way 1 (tag 2, age 3), clean, FILL only.
REQ-040 Store-miss fills 4 ways of set 2, then another tag -> WB of the LRU block with mem_req_write=1 and its old address, then FILL.
REQ-041 Assert rst in FILL before ack -> mem_req_valid=0 immediately, no resp_valid; repeating the request misses again.
REQ-042 Hold req_valid through a miss; hold mem_ack high continuously -> exactly one acceptance and one response per request.

Source files
------------

// File: rtl/set_lookup_ctrl.sv
// Set-associative tag lookup controller: tag/LRU store, hit/miss resolution,
// victim writeback and fill sequencing toward memory, one response per request.
module set_lookup_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int TAG_W    = 24,
   parameter int INDEX_W  = 2,
   parameter int OFFSET_W = 6,
   parameter int WAYS     = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [ADDR_W-1:0]                 req_addr,
   input  logic                              req_write,
   output logic                              resp_valid,
   output logic                              resp_hit,
   output logic [INDEX_W+$clog2(WAYS)-1:0]   block_num,
   output logic                              set_enable,
   output logic                              mem_req_valid,
   output logic                              mem_req_write,
   output logic [ADDR_W-1:0]                 mem_req_addr,
   input  logic                              mem_ack,
   output logic [2:0]                        dbg_state
);

   localparam int WAY_W = $clog2(WAYS);
   localparam int SETS  = 1 << INDEX_W;

   // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
   // a memory request completes on a rising edge where mem_req_valid && mem_ack.
   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

   state_t                r_state;
   logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
   logic [WAY_W-1:0]      r_age   [SETS][WAYS];
   logic [WAYS-1:0]       r_valid [SETS];
   logic [WAYS-1:0]       r_dirty [SETS];

   logic [TAG_W-1:0]      r_req_tag;
   logic [INDEX_W-1:0]    r_req_idx;
   logic                  r_req_wr;
   logic [WAY_W-1:0]      r_way;

   logic                  r_resp_valid;
   logic                  r_resp_hit;
   logic [INDEX_W+WAY_W-1:0] r_block_num;
   logic                  r_set_enable;
   logic                  r_mem_req_valid;
   logic                  r_mem_req_write;
   logic [ADDR_W-1:0]     r_mem_req_addr;

   logic                  w_hit;
   logic [WAY_W-1:0]      w_hit_way;
   logic                  w_inv_found;
   logic [WAY_W-1:0]      w_inv_way;
   logic [WAY_W-1:0]      w_lru_way;
   logic [WAY_W-1:0]      w_victim;
   logic [WAY_W-1:0]      w_old_age;
   logic                  w_unused_offset;

   assign w_unused_offset = ^req_addr[OFFSET_W-1:0];

   // Descending scan so the lowest-index match wins.
   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      w_lru_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (r_valid[r_req_idx][w] && (r_tag[r_req_idx][w] == r_req_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!r_valid[r_req_idx][w]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
         if (r_age[r_req_idx][w] == WAY_W'(WAYS - 1)) begin
            w_lru_way = WAY_W'(w);
         end
      end
      w_victim  = w_inv_found ? w_inv_way : w_lru_way;
      w_old_age = r_age[r_req_idx][r_way];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_req_tag       <= '0;
         r_req_idx       <= '0;
         r_req_wr        <= 1'b0;
         r_way           <= '0;
         r_resp_valid    <= 1'b0;
         r_resp_hit      <= 1'b0;
         r_block_num     <= '0;
         r_set_enable    <= 1'b0;
         r_mem_req_valid <= 1'b0;
         r_mem_req_write <= 1'b0;
         r_mem_req_addr  <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               r_tag[s][w] <= '0;
               r_age[s][w] <= WAY_W'(w);
            end
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_req_tag <= req_addr[ADDR_W-1 -: TAG_W];
                  r_req_idx <= req_addr[OFFSET_W +: INDEX_W];
                  r_req_wr  <= req_write;
                  r_state   <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (w_hit) begin
                  r_way        <= w_hit_way;
                  if (r_req_wr) r_dirty[r_req_idx][w_hit_way] <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_resp_hit   <= 1'b1;
                  r_set_enable <= 1'b1;
                  r_block_num  <= {r_req_idx, w_hit_way};
                  r_state      <= S_RESP;
               end else begin
                  r_way           <= w_victim;
                  r_resp_hit      <= 1'b0;
                  r_mem_req_valid <= 1'b1;
                  if (r_valid[r_req_idx][w_victim] && r_dirty[r_req_idx][w_victim]) begin
                     r_mem_req_write <= 1'b1;
                     r_mem_req_addr  <= {r_tag[r_req_idx][w_victim], r_req_idx, {OFFSET_W{1'b0}}};
                     r_state         <= S_WB;
                  end else begin
                     r_mem_req_write <= 1'b0;
                     r_mem_req_addr  <= {r_req_tag, r_req_idx, {OFFSET_W{1'b0}}};
                     r_state         <= S_FILL;
                  end
               end
            end
            S_WB: begin
               // Fill follows immediately, so mem_req_valid stays up across the switch.
               if (mem_ack) begin
                  r_mem_req_write <= 1'b0;
                  r_mem_req_addr  <= {r_req_tag, r_req_idx, {OFFSET_W{1'b0}}};
                  r_state         <= S_FILL;
               end
            end
            S_FILL: begin
               if (mem_ack) begin
                  r_mem_req_valid             <= 1'b0;
                  r_tag[r_req_idx][r_way]     <= r_req_tag;
                  r_valid[r_req_idx][r_way]   <= 1'b1;
                  r_dirty[r_req_idx][r_way]   <= r_req_wr;
                  r_resp_valid                <= 1'b1;
                  r_set_enable                <= 1'b1;
                  r_block_num                 <= {r_req_idx, r_way};
                  r_state                     <= S_RESP;
               end
            end
            S_RESP: begin
               r_resp_valid <= 1'b0;
               r_set_enable <= 1'b0;
               for (int w = 0; w < WAYS; w++) begin
                  if (WAY_W'(w) == r_way) begin
                     r_age[r_req_idx][w] <= '0;
                  end else if (r_age[r_req_idx][w] < w_old_age) begin
                     r_age[r_req_idx][w] <= r_age[r_req_idx][w] + 1'b1;
                  end
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = (r_state == S_IDLE) && !rst;
   assign resp_valid    = r_resp_valid;
   assign resp_hit      = r_resp_hit;
   assign block_num     = r_block_num;
   assign set_enable    = r_set_enable;
   assign mem_req_valid = r_mem_req_valid;
   assign mem_req_write = r_mem_req_write;
   assign mem_req_addr  = r_mem_req_addr;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_set_lookup_ctrl.sv
// Bench for set_lookup_ctrl: directed scenarios plus randomized traffic checked
// against a recency-list cache model and an expected memory-request queue.
module tb_set_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, resp_valid, resp_hit, set_enable, mem_req_valid, mem_req_write;
  logic [3:0]  block_num;
  logic [31:0] mem_req_addr;
  logic [2:0]  dbg_state;

  set_lookup_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .block_num(block_num), .set_enable(set_enable),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int acc_cnt = 0;
  int resp_cnt = 0;

  always @(posedge clk) begin
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // Reference model: per-set recency list, most recent first.
  logic        m_valid [4][4];
  logic        m_dirty [4][4];
  logic [23:0] m_tag   [4][4];
  int          m_lru   [4][$];
  logic [32:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_lru[s].delete();
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_lru[s].push_back(w);
      end
    end
  endtask

  task automatic run_req(input logic [31:0] addr, input logic wr, input int ack_lat,
                         input bit hold, input bit ack_always);
    int s, way, cyc, wait_cnt, acc0, resp0;
    bit hit, done;
    logic [23:0] tg;
    logic [32:0] got, exp;
    s = int'(addr[7:6]);
    tg = addr[31:8];
    hit = 1'b0;
    way = -1;
    for (int w = 0; w < 4; w++)
      if (!hit && m_valid[s][w] && m_tag[s][w] == tg) begin hit = 1'b1; way = w; end
    if (hit) begin
      if (wr) m_dirty[s][way] = 1'b1;
    end else begin
      for (int w = 0; w < 4; w++)
        if (way < 0 && !m_valid[s][w]) way = w;
      if (way < 0) way = m_lru[s][3];
      if (m_valid[s][way] && m_dirty[s][way])
        exp_q.push_back({1'b1, m_tag[s][way], 2'(s), 6'b0});
      exp_q.push_back({1'b0, tg, 2'(s), 6'b0});
      m_tag[s][way]   = tg;
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = wr;
    end
    for (int i = 0; i < m_lru[s].size(); i++)
      if (m_lru[s][i] == way) begin m_lru[s].delete(i); break; end
    m_lru[s].push_front(way);

    acc0 = acc_cnt;
    resp0 = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    if (ack_always) mem_ack = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check_eq("accept", req_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_write = 1'($urandom_range(0, 1));
    end
    cyc = 0;
    wait_cnt = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        done = 1'b1;
        check_eq("resp_hit", resp_hit, hit);
        check_eq("block_num", block_num, {2'(s), 2'(way)});
        check_eq("set_enable", set_enable, 1);
        check_eq("mem_idle_at_resp", mem_req_valid, 0);
        if (hit) check_eq("hit_latency", cyc, 2);
        req_valid = 1'b0;
        mem_ack = 1'b0;
      end else if (!ack_always && mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req_valid) begin
        if (ack_always || wait_cnt == ack_lat) begin
          got = {mem_req_write, mem_req_addr};
          if (exp_q.size() > 0) exp = exp_q.pop_front();
          else exp = '1;
          check_eq("mem_req", got, exp);
          mem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    check_eq("resp_seen", done, 1);
    check_eq("mem_reqs_left", exp_q.size(), 0);
    exp_q.delete();
    mem_ack = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("resp_pulse", resp_valid, 0);
    @(negedge clk);
    check_eq("one_accept", acc_cnt - acc0, 1);
    check_eq("one_resp", resp_cnt - resp0, 1);
  endtask

  task automatic reset_in_fill(input logic [31:0] addr);
    int cyc, resp0;
    resp0 = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    while (!mem_req_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check_eq("fill_started", {mem_req_valid, mem_req_write, mem_req_addr}, {2'b10, addr[31:6], 6'b0});
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mem_valid", mem_req_valid, 0);
    check_eq("rst_mem_addr", mem_req_addr, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_resp", resp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("abort_no_resp", resp_cnt - resp0, 0);
    check_eq("ready_after_rst", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_ready_low", req_ready, 0);
    check_eq("rst_outputs", {resp_valid, resp_hit, set_enable, mem_req_valid, mem_req_write}, 0);
    check_eq("rst_block_num", block_num, 0);
    check_eq("rst_mem_addr0", mem_req_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_idle", req_ready, 1);

    // Cold miss then hit on the same block.
    run_req(32'h0000_1240, 1'b0, 2, 1'b0, 1'b0);
    run_req(32'h0000_1240, 1'b0, 0, 1'b0, 1'b0);

    // Set 0: four loads, store to tag 1, then a clean LRU eviction.
    for (int t = 1; t <= 4; t++) run_req({24'(t), 8'h00}, 1'b0, 1, 1'b0, 1'b0);
    run_req(32'h0000_0100, 1'b1, 0, 1'b0, 1'b0);
    run_req(32'h0000_0500, 1'b0, 0, 1'b0, 1'b0);

    // Set 2: store misses fill all ways, the next tag forces a writeback.
    for (int t = 1; t <= 4; t++) run_req({24'(16 + t), 8'h80}, 1'b1, t - 1, 1'b0, 1'b0);
    run_req(32'h0000_2080, 1'b0, 2, 1'b0, 1'b0);

    // Reset during a fill aborts it; the same request misses again.
    reset_in_fill(32'h0000_33C0);
    run_req(32'h0000_33C0, 1'b0, 1, 1'b0, 1'b0);

    // req_valid held through the transaction, mem_ack held high throughout.
    run_req(32'h0000_77C0, 1'b0, 0, 1'b1, 1'b1);
    run_req(32'h0000_77C0, 1'b1, 0, 1'b1, 1'b1);
    for (int t = 1; t <= 4; t++) run_req({24'(t + 8), 8'hC0}, 1'b1, 0, 1'b1, 1'b1);

    for (int n = 0; n < 120; n++) begin
      a = {24'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      run_req(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
